// File: rtl/config_pkg.sv
// Core configuration record for standalone builds of the SPMP checker.
// Carries only the fields the checker needs from the core config.
package config_pkg;

  typedef struct packed {
    int unsigned NrSPMPEntries;
    int unsigned XLEN;
    int unsigned PLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{NrSPMPEntries: 64, XLEN: 32, PLEN: 34};

endpackage

// File: rtl/spmp_pkg.sv
// Shared types for the SPMP permission checker: entry config layout, address-match modes,
// access kinds and the arbiter FSM states.
package spmp_pkg;

  typedef enum logic [1:0] {
    AOff   = 2'd0,
    ATor   = 2'd1,
    ANa4   = 2'd2,
    ANapot = 2'd3
  } spmp_a_e;

  typedef enum logic [1:0] {
    AccR = 2'd0,
    AccW = 2'd1,
    AccX = 2'd2
  } spmp_access_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWalk = 2'd1,
    StResp = 2'd2
  } spmp_state_e;

  typedef struct packed {
    logic    rsvd7;
    logic    u;
    logic    rsvd5;
    spmp_a_e a;
    logic    x;
    logic    w;
    logic    r;
  } spmp_cfg_t;

  localparam logic [1:0] PrivU = 2'd0;
  localparam logic [1:0] PrivS = 2'd1;
  localparam logic [1:0] PrivM = 2'd3;

  // U-mode may only use U=1 entries, S-mode only U=0 entries.
  function automatic logic spmp_allow(spmp_cfg_t cfg, spmp_access_e acc, logic [1:0] priv);
    logic perm;
    logic mode_ok;
    case (acc)
      AccX:    perm = cfg.x;
      AccW:    perm = cfg.w;
      default: perm = cfg.r;
    endcase
    if (priv == PrivU) begin
      mode_ok = cfg.u;
    end else if (priv == PrivS) begin
      mode_ok = !cfg.u;
    end else begin
      mode_ok = 1'b0;
    end
    return perm && mode_ok;
  endfunction

endpackage

// File: rtl/spmp_entry_match.sv
// Single SPMP entry address comparator (TOR / NA4 / NAPOT) on word addresses.
module spmp_entry_match
  import spmp_pkg::*;
#(
  parameter int unsigned AddrW = 32
) (
  input  logic [AddrW-1:0] addr_i,
  input  logic [AddrW-1:0] lo_i,
  input  logic [AddrW-1:0] ent_i,
  input  spmp_a_e          mode_i,
  output logic             match_o
);

  logic [AddrW-1:0] napot_mask;

  always_comb begin
    // Trailing ones plus the first zero of the entry address are don't-care bits.
    napot_mask = ~(ent_i ^ (ent_i + AddrW'(1)));
    match_o    = 1'b0;
    unique case (mode_i)
      ATor:    match_o = (addr_i >= lo_i) && (addr_i < ent_i);
      ANa4:    match_o = (addr_i == ent_i);
      ANapot:  match_o = ((addr_i ^ ent_i) & napot_mask) == '0;
      default: match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/spmp_check_arbiter.sv
// Arbitrates fetch and LSU permission checks and walks the SPMP table Lanes entries per cycle,
// reporting the lowest-index match.
module spmp_check_arbiter
  import spmp_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned Lanes = 8
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_ni,
  input  logic                                                      flush_i,
  input  logic                                                      fetch_valid_i,
  output logic                                                      fetch_ready_o,
  input  logic [CVA6Cfg.PLEN-1:0]                                   fetch_addr_i,
  input  logic                                                      data_valid_i,
  output logic                                                      data_ready_o,
  input  logic [CVA6Cfg.PLEN-1:0]                                   data_addr_i,
  input  logic                                                      data_we_i,
  input  logic [1:0]                                                priv_lvl_i,
  input  logic [CVA6Cfg.NrSPMPEntries-1:0][7:0]                     spmp_cfg_i,
  input  logic [CVA6Cfg.NrSPMPEntries-1:0][CVA6Cfg.PLEN-3:0]        spmp_addr_i,
  output logic                                                      resp_valid_o,
  output logic                                                      resp_id_o,
  output logic                                                      resp_allow_o,
  output logic                                                      resp_match_o,
  output logic [$clog2(CVA6Cfg.NrSPMPEntries)-1:0]                  resp_idx_o
);

  localparam int unsigned NrEntries = CVA6Cfg.NrSPMPEntries;
  localparam int unsigned Plen      = CVA6Cfg.PLEN;
  localparam int unsigned WordW     = Plen - 2;
  localparam int unsigned IdxW      = $clog2(NrEntries);
  localparam int unsigned NrBatches = NrEntries / Lanes;
  localparam int unsigned BatchW    = (NrBatches > 1) ? $clog2(NrBatches) : 1;
  localparam logic [BatchW-1:0] LastBatch = BatchW'(NrBatches - 1);

  if (NrEntries % Lanes != 0) begin : gen_lanes_check
    $error("NrSPMPEntries must be a multiple of Lanes");
  end

  spmp_state_e         state_q, state_d;
  logic [BatchW-1:0]   batch_q, batch_d;
  logic                last_data_q, last_data_d;
  logic [WordW-1:0]    req_addr_q, req_addr_d;
  spmp_access_e        req_acc_q, req_acc_d;
  logic                req_id_q, req_id_d;
  logic [1:0]          req_priv_q, req_priv_d;
  logic                resp_id_q, resp_id_d;
  logic                resp_allow_q, resp_allow_d;
  logic                resp_match_q, resp_match_d;
  logic [IdxW-1:0]     resp_idx_q, resp_idx_d;

  logic [Lanes-1:0]             lane_hit;
  logic [Lanes-1:0][IdxW-1:0]   lane_idx;
  spmp_cfg_t [Lanes-1:0]        lane_cfg;
  logic [Lanes-1:0][WordW-1:0]  lane_lo;
  logic [Lanes-1:0][WordW-1:0]  lane_ent;
  logic [IdxW-1:0]              batch_base;
  logic                         hit_any;
  logic [IdxW-1:0]              hit_idx;
  spmp_cfg_t                    hit_cfg;
  logic                         grant_fetch;
  logic                         unused_addr_lsbs;

  assign unused_addr_lsbs = ^{fetch_addr_i[1:0], data_addr_i[1:0]};

  // Lane inputs; lane 0 of a later batch takes its TOR lower bound from the previous batch.
  always_comb begin
    batch_base = IdxW'(batch_q * Lanes);
    for (int unsigned l = 0; l < Lanes; l++) begin
      lane_idx[l] = batch_base + IdxW'(l);
      lane_cfg[l] = spmp_cfg_t'(spmp_cfg_i[lane_idx[l]]);
      lane_ent[l] = spmp_addr_i[lane_idx[l]];
      if (lane_idx[l] == '0) begin
        lane_lo[l] = '0;
      end else begin
        lane_lo[l] = spmp_addr_i[lane_idx[l] - IdxW'(1)];
      end
    end
  end

  for (genvar l = 0; l < Lanes; l++) begin : gen_lane
    spmp_entry_match #(
      .AddrW (WordW)
    ) u_match (
      .addr_i  (req_addr_q),
      .lo_i    (lane_lo[l]),
      .ent_i   (lane_ent[l]),
      .mode_i  (lane_cfg[l].a),
      .match_o (lane_hit[l])
    );
  end

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    hit_cfg = '0;
    for (int l = int'(Lanes) - 1; l >= 0; l--) begin
      if (lane_hit[l]) begin
        hit_any = 1'b1;
        hit_idx = lane_idx[l];
        hit_cfg = lane_cfg[l];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    batch_d       = batch_q;
    last_data_d   = last_data_q;
    req_addr_d    = req_addr_q;
    req_acc_d     = req_acc_q;
    req_id_d      = req_id_q;
    req_priv_d    = req_priv_q;
    resp_id_d     = resp_id_q;
    resp_allow_d  = resp_allow_q;
    resp_match_d  = resp_match_q;
    resp_idx_d    = resp_idx_q;
    fetch_ready_o = 1'b0;
    data_ready_o  = 1'b0;
    resp_valid_o  = 1'b0;
    // Fetch wins unless data is also waiting and fetch was granted last.
    grant_fetch   = fetch_valid_i && (!data_valid_i || last_data_q);

    unique case (state_q)
      StIdle: begin
        if (!flush_i) begin
          fetch_ready_o = grant_fetch;
          data_ready_o  = data_valid_i && !grant_fetch;
          if (fetch_valid_i || data_valid_i) begin
            req_id_d    = !grant_fetch;
            last_data_d = !grant_fetch;
            req_addr_d  = grant_fetch ? fetch_addr_i[Plen-1:2] : data_addr_i[Plen-1:2];
            req_acc_d   = grant_fetch ? AccX : (data_we_i ? AccW : AccR);
            req_priv_d  = priv_lvl_i;
            batch_d     = '0;
            if (priv_lvl_i == PrivM) begin
              state_d      = StResp;
              resp_id_d    = !grant_fetch;
              resp_allow_d = 1'b1;
              resp_match_d = 1'b0;
              resp_idx_d   = '0;
            end else begin
              state_d = StWalk;
            end
          end
        end
      end
      StWalk: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (hit_any) begin
          state_d      = StResp;
          resp_id_d    = req_id_q;
          resp_match_d = 1'b1;
          resp_idx_d   = hit_idx;
          resp_allow_d = spmp_allow(hit_cfg, req_acc_q, req_priv_q);
        end else if (batch_q == LastBatch) begin
          state_d      = StResp;
          resp_id_d    = req_id_q;
          resp_match_d = 1'b0;
          resp_idx_d   = '0;
          resp_allow_d = 1'b0;
        end else begin
          batch_d = batch_q + BatchW'(1);
        end
      end
      StResp: begin
        resp_valid_o = !flush_i;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      batch_q      <= '0;
      last_data_q  <= 1'b1;
      req_addr_q   <= '0;
      req_acc_q    <= AccR;
      req_id_q     <= 1'b0;
      req_priv_q   <= '0;
      resp_id_q    <= 1'b0;
      resp_allow_q <= 1'b0;
      resp_match_q <= 1'b0;
      resp_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      batch_q      <= batch_d;
      last_data_q  <= last_data_d;
      req_addr_q   <= req_addr_d;
      req_acc_q    <= req_acc_d;
      req_id_q     <= req_id_d;
      req_priv_q   <= req_priv_d;
      resp_id_q    <= resp_id_d;
      resp_allow_q <= resp_allow_d;
      resp_match_q <= resp_match_d;
      resp_idx_q   <= resp_idx_d;
    end
  end

  assign resp_id_o    = resp_id_q;
  assign resp_allow_o = resp_allow_q;
  assign resp_match_o = resp_match_q;
  assign resp_idx_o   = resp_idx_q;

endmodule

// File: doc/spmp_check_arbiter.md
SPMP_CHECK_ARBITER -- requirements
Module: spmp_check_arbiter

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core config supplying NrSPMPEntries, XLEN and PLEN.
REQ-002 SHALL have parameter Lanes, default 8, number of SPMP entries checked per cycle; NrSPMPEntries % Lanes == 0 is required, enforced by an elaboration assertion.
REQ-003 SHALL have ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  abort the in-flight check.
- fetch_valid_i, fetch_ready_o  in/out  1  fetch request handshake.
- fetch_addr_i  in  PLEN  fetch physical address.
- data_valid_i, data_ready_o  in/out  1  LSU request handshake.
- data_addr_i  in  PLEN  LSU physical address.
- data_we_i  in  1  1=store, 0=load.
- priv_lvl_i  in  2  effective privilege level (M=3, S=1, U=0).
- spmp_cfg_i  in  NrSPMPEntries x 8  per-entry config: R[0], W[1], X[2], A[4:3], U[6].
- spmp_addr_i  in  NrSPMPEntries x (PLEN-2)  per-entry address, holding addr[PLEN-1:2].
- resp_valid_o  out  1  one-cycle result strobe.
- resp_id_o  out  1  0=fetch, 1=data.
- resp_allow_o  out  1  access permitted.
- resp_match_o  out  1  an entry matched.
- resp_idx_o  out  $clog2(NrSPMPEntries)  index of the matching entry.

Function
REQ-004 SHALL implement FSM IDLE -> WALK -> RESP -> IDLE.
REQ-005 SHALL assert ready only in IDLE with flush_i=0, and only to the granted requester.
REQ-006 SHALL grant the only valid requester; if both are valid, it SHALL grant the one not granted last; the last-grant register SHALL reset to data, so fetch wins first.
REQ-007 SHALL capture address, access type (fetch=X, load=R, store=W), requester id and priv_lvl_i on handshake.
REQ-008 SHALL go from IDLE to RESP on an M-mode request, with allow=1, match=0, idx=0, and no walk.
REQ-009 SHALL, in WALK, evaluate entries [k*Lanes, k*Lanes+Lanes-1] in batch cycle k, with k counting from 0.
REQ-010 SHALL use this matching rule for A: 0=OFF (no match), 1=TOR, 2=NA4, 3=NAPOT.
- TOR entry 0 uses lower bound 0.
- TOR lane 0 of batch k>0 uses entry k*Lanes-1 as its lower bound.
REQ-011 SHALL stop at the lowest-index match: record idx and go to RESP in the next cycle.
REQ-012 SHALL compute allow for a match as permission bit set AND (U=1 for U-mode, U=0 for S-mode).
REQ-013 SHALL, if the last batch has no match, go to RESP with match=0, allow=0.
REQ-014 SHALL assert resp_valid_o for exactly one cycle, in RESP; the result outputs SHALL be held stable otherwise and SHALL NOT be backpressured.
REQ-015 SHALL have latency, from handshake cycle t, of:
- M-mode: resp at t+1.
- Match in batch k: resp at t+2+k.
- No match: resp at t+1+NrSPMPEntries/Lanes.
REQ-016 SHALL, on flush_i in WALK or RESP, return to IDLE next cycle with no resp_valid_o for that request; flush_i takes priority over RESP.
REQ-017 SHALL sample spmp_cfg_i and spmp_addr_i live during WALK; software fences config writes, and mid-walk changes are not required to be coherent.
REQ-018 SHALL allow a new handshake in the cycle after RESP; there SHALL be no back-to-back accept in RESP.

Reset
REQ-019 SHALL, on rst_ni low, asynchronously set:
- state=IDLE and batch counter=0.
- last-grant=data.
- resp_valid_o=0, resp_id_o=0, resp_allow_o=0, resp_match_o=0, resp_idx_o=0.
- captured request registers=0.
REQ-020 SHALL drop an in-flight walk on reset assertion mid-operation, with no response.

Structure
REQ-021 SHALL take from shared package spmp_pkg:
- spmp_cfg_t bitfield struct.
- A-mode enum (OFF/TOR/NA4/NAPOT).
- access enum (R/W/X).
- FSM state enum.
REQ-022 SHALL instantiate sub-module spmp_entry_match, the single-entry TOR/NA4/NAPOT address comparator, Lanes times.

Verification
REQ-023 Directed scenarios, with NrSPMPEntries=64 and Lanes=8:
- S-mode load 0x8000_1000; entry 3 NAPOT 0x8000_0000/64KiB, cfg R=1, U=0 -> resp at t+2, allow=1, match=1, idx=3.
- U-mode fetch same address; entry 3 with U=0 -> allow=0, match=1, idx=3.
- S-mode store 0x9000_0000; all entries OFF -> resp at t+9, allow=0, match=0.
- Match in entry 42 (TOR 0x1000..0x2000, addr 0x1800) -> resp at t+7, idx=42; entry 41 supplies the bound.
- Fetch and data valid every cycle -> grants alternate fetch, data, fetch; fetch goes first after reset.
- M-mode store -> resp at t+1, allow=1; flush_i during a 9-cycle walk -> no resp, ready high next cycle.
